// File: rtl/lsu_mem_if.sv
// rtl/lsu_mem_if.sv - MEM-stage load/store unit driving a req/gnt/rvalid data bus
//
// Purpose: accepts a load or store from the MEM stage, checks alignment,
// issues one bus access with lane-shifted write data and byte enables,
// extracts and extends load data, and stalls the pipeline until done.
//
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_valid, i_memwrite, i_memread MEM-stage access request
//   i_f3, i_addr, i_wdata          width/sign, byte address, right-aligned store data
//   o_stall, o_done, o_rdata       pipeline freeze, completion pulse, extended load data
//   o_misaligned, o_bus_err        alignment fault pulse, timeout pulse
//   o_mem_*                        bus request side (req, we, word addr, be, wdata)
//   i_mem_gnt, i_mem_rvalid, i_mem_rdata  bus response side
module lsu_mem_if #(
  parameter int unsigned P_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_memwrite,
  input  logic        i_memread,
  input  logic [2:0]  i_f3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_bus_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_R,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        bus_err_q;
  logic [31:0] cnt_q;

  logic        access;
  logic        is_byte;
  logic        is_half;
  logic        misaligned;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] lane;
  logic [31:0] rdata_d;
  logic        timeout_hit;

  // Request decode and store-side lane steering for the accept cycle.
  always_comb begin
    access     = 1'b0;
    is_byte    = 1'b0;
    is_half    = 1'b0;
    misaligned = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = 32'd0;

    access  = i_valid & (i_memwrite | i_memread) & (state_q == S_IDLE) & ~i_rst;
    // f3[1:0]: 00 byte, 01 half, anything with bit 1 set (incl. reserved) is a word.
    is_byte = (i_f3[1:0] == 2'b00);
    is_half = (i_f3[1:0] == 2'b01);

    misaligned = access & ((is_half & i_addr[0]) |
                           (~is_byte & ~is_half & (i_addr[1:0] != 2'b00)));

    if (is_byte) begin
      be_d = 4'b0001 << i_addr[1:0];
    end else if (is_half) begin
      be_d = i_addr[1] ? 4'b1100 : 4'b0011;
    end else begin
      be_d = 4'b1111;
    end

    if (i_memwrite) begin
      wdata_d = i_wdata << {i_addr[1:0], 3'b000};
    end
  end

  // Load-side lane extraction from the returned word.
  always_comb begin
    lane    = i_mem_rdata >> {addr_q[1:0], 3'b000};
    rdata_d = lane;
    case (f3_q)
      3'b000:  rdata_d = {{24{lane[7]}}, lane[7:0]};
      3'b100:  rdata_d = {24'd0, lane[7:0]};
      3'b001:  rdata_d = {{16{lane[15]}}, lane[15:0]};
      3'b101:  rdata_d = {16'd0, lane[15:0]};
      default: rdata_d = lane;
    endcase
  end

  // True in the busy cycle after which the counter would reach P_TIMEOUT.
  assign timeout_hit = (P_TIMEOUT != 0) && ((cnt_q + 32'd1) == P_TIMEOUT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      addr_q    <= 32'd0;
      f3_q      <= 3'd0;
      we_q      <= 1'b0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      bus_err_q <= 1'b0;
      cnt_q     <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (access && !misaligned) begin
            addr_q  <= i_addr;
            f3_q    <= i_f3;
            we_q    <= i_memwrite;  // memwrite wins when both are set
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= 32'd0;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + 32'd1;
          if (i_mem_gnt) begin
            if (we_q) begin
              rdata_q <= 32'd0;
              state_q <= S_DONE;
            end else if (i_mem_rvalid) begin
              rdata_q <= rdata_d;
              state_q <= S_DONE;
            end else begin
              state_q <= S_WAIT_R;
            end
          end else if (timeout_hit) begin
            rdata_q   <= 32'd0;
            bus_err_q <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_WAIT_R: begin
          cnt_q <= cnt_q + 32'd1;
          if (i_mem_rvalid) begin
            rdata_q <= rdata_d;
            state_q <= S_DONE;
          end else if (timeout_hit) begin
            rdata_q   <= 32'd0;
            bus_err_q <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        default: begin
          rdata_q   <= 32'd0;
          bus_err_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  // Bus fields are only driven while the request is outstanding.
  assign o_mem_req    = (state_q == S_REQ);
  assign o_mem_we     = o_mem_req & we_q;
  assign o_mem_addr   = o_mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign o_mem_be     = o_mem_req ? be_q : 4'd0;
  assign o_mem_wdata  = o_mem_req ? wdata_q : 32'd0;

  assign o_stall      = (state_q == S_REQ) | (state_q == S_WAIT_R) | (access & ~misaligned);
  assign o_misaligned = misaligned;
  assign o_done       = (state_q == S_DONE);
  assign o_rdata      = rdata_q;
  assign o_bus_err    = bus_err_q;

endmodule
